// File: rtl/alu_multicycle.sv
// Handshaked, registered ALU: single-cycle ops at one result per cycle and an
// iterative shift-add signed multiply taking WIDTH cycles, with optional saturation.
module alu_multicycle #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clock_in,
    input  logic             reset_in,
    input  logic             enable_in,
    input  logic [7:0]       opcode_in,
    input  logic [WIDTH-1:0] alu_input1,
    input  logic [WIDTH-1:0] alu_input2,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] alu_output,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       flags
);

    localparam logic [7:0] OP_ADD = 8'd0;
    localparam logic [7:0] OP_SUB = 8'd1;
    localparam logic [7:0] OP_MUL = 8'd2;
    localparam logic [7:0] OP_EQ  = 8'd3;
    localparam logic [7:0] OP_GT  = 8'd4;
    localparam logic [7:0] OP_LT  = 8'd5;
    localparam logic [7:0] OP_AND = 8'd6;
    localparam logic [7:0] OP_OR  = 8'd7;
    localparam logic [7:0] OP_XOR = 8'd8;
    localparam logic [7:0] OP_SHL = 8'd9;
    localparam logic [7:0] OP_SRA = 8'd10;

    localparam int              CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] SMAX     = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN     = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t               state_reg;
    logic [2*WIDTH-1:0]   mul_acc_reg;
    logic [2*WIDTH-1:0]   mul_mcand_reg;
    logic [WIDTH-1:0]     mul_mplier_reg;
    logic                 mul_neg_reg;
    logic [CW-1:0]        mul_cnt_reg;

    logic                 accept;
    logic [WIDTH:0]       sum_ext;
    logic [WIDTH:0]       diff_ext;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     mul_res;
    logic                 mul_ovf;
    logic [WIDTH-1:0]     op_res;
    logic                 op_ovf;
    logic                 op_ill;

    function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] r,
                                              input logic ovf, input logic ill);
        return {ovf, r[WIDTH-1], (r == '0), ill};
    endfunction

    assign in_ready = enable_in && (state_reg == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    assign sum_ext  = {alu_input1[WIDTH-1], alu_input1} + {alu_input2[WIDTH-1], alu_input2};
    assign diff_ext = {alu_input1[WIDTH-1], alu_input1} - {alu_input2[WIDTH-1], alu_input2};

    // Magnitudes are unsigned, so -2^(WIDTH-1) still fits in WIDTH bits.
    assign mag_a = alu_input1[WIDTH-1] ? ('0 - alu_input1) : alu_input1;
    assign mag_b = alu_input2[WIDTH-1] ? ('0 - alu_input2) : alu_input2;

    assign acc_step = mul_acc_reg + (mul_mplier_reg[0] ? mul_mcand_reg : '0);
    assign prod     = mul_neg_reg ? ('0 - acc_step) : acc_step;
    // Representable in WIDTH bits only when the upper WIDTH+1 bits are a pure sign extension.
    assign mul_ovf  = ~((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]));
    assign mul_res  = (SATURATE && mul_ovf) ? (prod[2*WIDTH-1] ? SMIN : SMAX)
                                            : prod[WIDTH-1:0];

    always_comb begin
        op_res = '0;
        op_ovf = 1'b0;
        op_ill = 1'b0;
        case (opcode_in)
            OP_ADD: begin
                op_ovf = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
                op_res = (SATURATE && op_ovf) ? (sum_ext[WIDTH] ? SMIN : SMAX)
                                              : sum_ext[WIDTH-1:0];
            end
            OP_SUB: begin
                op_ovf = diff_ext[WIDTH] ^ diff_ext[WIDTH-1];
                op_res = (SATURATE && op_ovf) ? (diff_ext[WIDTH] ? SMIN : SMAX)
                                              : diff_ext[WIDTH-1:0];
            end
            OP_MUL: op_res = '0;
            OP_EQ:  op_res = {{(WIDTH-1){1'b0}}, (alu_input1 == alu_input2)};
            OP_GT:  op_res = {{(WIDTH-1){1'b0}}, ($signed(alu_input1) > $signed(alu_input2))};
            OP_LT:  op_res = {{(WIDTH-1){1'b0}}, ($signed(alu_input1) < $signed(alu_input2))};
            OP_AND: op_res = alu_input1 & alu_input2;
            OP_OR:  op_res = alu_input1 | alu_input2;
            OP_XOR: op_res = alu_input1 ^ alu_input2;
            // Full-width unsigned amounts: >= WIDTH naturally yields 0 / sign fill.
            OP_SHL: op_res = alu_input1 << alu_input2;
            OP_SRA: op_res = $signed(alu_input1) >>> alu_input2;
            default: op_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_reg      <= S_IDLE;
            alu_output     <= '0;
            flags          <= '0;
            out_valid      <= 1'b0;
            mul_acc_reg    <= '0;
            mul_mcand_reg  <= '0;
            mul_mplier_reg <= '0;
            mul_neg_reg    <= 1'b0;
            mul_cnt_reg    <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        if (opcode_in == OP_MUL) begin
                            mul_acc_reg    <= '0;
                            mul_mcand_reg  <= {{WIDTH{1'b0}}, mag_a};
                            mul_mplier_reg <= mag_b;
                            mul_neg_reg    <= alu_input1[WIDTH-1] ^ alu_input2[WIDTH-1];
                            mul_cnt_reg    <= '0;
                            state_reg      <= S_MUL;
                        end else begin
                            alu_output <= op_res;
                            flags      <= make_flags(op_res, op_ovf, op_ill);
                            out_valid  <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    mul_acc_reg    <= acc_step;
                    mul_mcand_reg  <= mul_mcand_reg << 1;
                    mul_mplier_reg <= mul_mplier_reg >> 1;
                    mul_cnt_reg    <= mul_cnt_reg + CW'(1);
                    if (mul_cnt_reg == LAST_STEP) begin
                        alu_output <= mul_res;
                        flags      <= make_flags(mul_res, mul_ovf, 1'b0);
                        out_valid  <= 1'b1;
                        state_reg  <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
Parametrised, handshaked successor to the single-cycle combinational ALU. It registers every result and accepts operations over a valid/ready interface. Single-cycle operations sustain one result per cycle; signed multiply runs as an iterative shift-add over WIDTH cycles. It extends the opcode set, adds an optional saturation mode and produces status flags. It sits between the instruction decode/issue stage and the register-file writeback.

Parameters:
WIDTH, 8, operand/result width in bits (>=4)
SATURATE, 0, 0 = wrap arithmetic results; 1 = clamp ADD/SUB/MUL to the signed range [-2^(WIDTH-1), 2^(WIDTH-1)-1]

Ports:
clock_in  input  1  sole clock; all state updates on rising edge
reset_in  input  1  asynchronous, active-low reset
enable_in  input  1  gates acceptance of new operations
opcode_in  input  8  operation select
alu_input1  input  WIDTH  signed operand A
alu_input2  input  WIDTH  signed operand B
in_valid  input  1  operation presented
in_ready  output  1  block can accept this cycle
alu_output  output  WIDTH  signed registered result
out_valid  output  1  alu_output/flags valid
out_ready  input  1  consumer takes result
flags  output  4  {overflow, negative, zero, illegal}, registered alongside alu_output

Behaviour:
- Reset (reset_in=0, asynchronous): state=IDLE, alu_output=0, flags=0, out_valid=0, multiply counter/accumulator cleared. Takes effect immediately, including mid-multiply; the in-flight operation is discarded. in_ready is 1 in the first cycle after release if enable_in=1.
- Opcodes:
  - 0 ADD; 1 SUB; 2 MUL.
  - 3 EQUALS, 4 GREATER_THAN, 5 LESS_THAN: result 1/0, signed compare.
  - 6 AND; 7 OR; 8 XOR.
  - 9 SHIFT_LEFT: logical shift of A by B.
  - 10 SHIFT_RIGHT_ARITH: arithmetic shift of A by B.
  - Any other opcode: result 0, illegal=1.
- Handshake: transfer when in_valid && in_ready. in_ready = enable_in && state==IDLE && (!out_valid || out_ready).
  - out_valid stays high until out_valid && out_ready.
  - alu_output and flags are stable while out_valid && !out_ready.
- FSM:
  - IDLE -> IDLE on a non-MUL transfer: result and flags loaded on the accepting edge; out_valid high next cycle (latency 1).
  - Simultaneous drain and accept is permitted, giving throughput of 1 op/cycle.
  - IDLE -> MUL on a MUL transfer: operand magnitudes, result sign and counter are latched on the accepting edge.
  - MUL: one shift-add step per edge; in_ready=0. After WIDTH steps, result and flags are loaded, out_valid rises, and the FSM returns to IDLE.
  - MUL latency: out_valid high exactly WIDTH cycles after the accepting edge.
  - enable_in=0 does not stall an in-progress MUL or the output register.
- Arithmetic:
  - ADD/SUB computed at WIDTH+1 bits. overflow=1 when the true result falls outside the signed WIDTH range.
  - MUL forms the full 2*WIDTH-bit signed product. overflow=1 when the product is not representable in WIDTH bits.
  - SATURATE=0: output the low WIDTH bits. SATURATE=1: clamp to max/min according to the sign of the true result.
  - overflow=0 for all other opcodes.
- Shifts: the shift amount is alu_input2 interpreted as unsigned.
  - Amount >= WIDTH: SHIFT_LEFT gives 0; SHIFT_RIGHT_ARITH gives all sign bits (0 or -1).
- Flags: zero = (final alu_output==0); negative = final alu_output MSB. Both are evaluated after wrap/saturation.

Test Plan:
- WIDTH=8, SATURATE=0: ADD 100+27 -> 127, flags 0000. ADD 100+28 -> -128, overflow=1, negative=1. SATURATE=1 with the same 100+28 -> 127, overflow=1.
- MUL -7*9 -> -63: out_valid rises exactly 8 cycles after accept, in_ready=0 throughout. MUL -128*-1 -> -128 with overflow=1 (SATURATE=0); 127 with overflow=1 (SATURATE=1).
- Backpressure: out_ready=0, accept ADD 1+2, then present SUB 5-3 -> in_ready=0 and alu_output held at 3. Raise out_ready -> 3 drains, SUB accepted, next result 2.
- Streaming: 4 consecutive ADDs (1+1, 2+2, 3+3, 4+4) with out_ready=1 -> results 2,4,6,8 on 4 consecutive cycles.
- Shifts/illegal: SHIFT_RIGHT_ARITH -64 by 3 -> -8. SHIFT_LEFT 1 by 9 -> 0, zero=1. Opcode 0xFF -> 0, illegal=1, zero=1. EQUALS 5,5 -> 1.
- Reset mid-MUL: assert reset_in=0 on the 4th cycle of MUL -> out_valid=0 immediately, alu_output=0. After release: in_ready=1, and a new ADD 2+3 -> 5.
